// File: rtl/conv_stream_master.sv
// Host-side stream engine: replays ifmap then weight words from a source RAM as
// AXI-Stream masters, then sinks the accelerator's result stream into a destination RAM.
module conv_stream_master #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_SIZE  = 16,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_SIZE-1:0]  ifmap_base,
  input  logic [ADDR_SIZE-1:0]  weight_base,
  input  logic [ADDR_SIZE-1:0]  result_base,
  input  logic [LEN_WIDTH-1:0]  ifmap_len,
  input  logic [LEN_WIDTH-1:0]  weight_len,
  input  logic [LEN_WIDTH-1:0]  result_len,
  output logic                  src_rd_en,
  output logic [ADDR_SIZE-1:0]  src_rd_addr,
  input  logic [DATA_WIDTH-1:0] src_rd_data,
  output logic [DATA_WIDTH-1:0] ifmap_w_data,
  output logic                  ifmap_w_valid,
  output logic                  ifmap_w_last,
  input  logic                  ifmap_w_ready,
  output logic [DATA_WIDTH-1:0] weight_w_data,
  output logic                  weight_w_valid,
  output logic                  weight_w_last,
  input  logic                  weight_w_ready,
  input  logic [DATA_WIDTH-1:0] r_data,
  input  logic                  r_valid,
  input  logic                  r_last,
  output logic                  r_ready,
  output logic                  dst_wr_en,
  output logic [ADDR_SIZE-1:0]  dst_wr_addr,
  output logic [DATA_WIDTH-1:0] dst_wr_data,
  output logic                  busy,
  output logic                  done,
  output logic                  err_last
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SEND_I = 3'd1,
    SEND_W = 3'd2,
    RECV   = 3'd3,
    FIN    = 3'd4
  } state_t;

  state_t state, state_nxt;

  logic [ADDR_SIZE-1:0]  ifmap_base_q, weight_base_q, result_base_q;
  logic [LEN_WIDTH-1:0]  ifmap_len_q, weight_len_q, result_len_q;
  logic [LEN_WIDTH-1:0]  read_idx, send_idx, recv_idx;
  logic                  inflight;
  logic [1:0]            occ;
  logic                  wr_ptr, rd_ptr;
  logic [DATA_WIDTH-1:0] fifo_mem [2];

  logic                  start_acc, sending, send_w_phase;
  logic [ADDR_SIZE-1:0]  phase_base;
  logic [LEN_WIDTH-1:0]  phase_len;
  logic                  head_valid, head_ready, head_last;
  logic [DATA_WIDTH-1:0] head_data;
  logic                  pop, phase_done, rd_en;
  logic [2:0]            credit;
  logic                  recv_hs, recv_at_end, recv_end, recv_err;

  // First non-empty phase among the remaining ones; FIN when nothing is left.
  function automatic state_t first_phase(input logic i_nz, input logic w_nz,
                                         input logic r_nz);
    if (i_nz)      return SEND_I;
    else if (w_nz) return SEND_W;
    else if (r_nz) return RECV;
    else           return FIN;
  endfunction

  assign start_acc    = start && (state == IDLE);
  assign sending      = (state == SEND_I) || (state == SEND_W);
  assign send_w_phase = (state == SEND_W);
  assign phase_base   = send_w_phase ? weight_base_q : ifmap_base_q;
  assign phase_len    = send_w_phase ? weight_len_q : ifmap_len_q;

  assign head_valid = sending && (occ != 2'd0);
  assign head_data  = fifo_mem[rd_ptr];
  assign head_ready = send_w_phase ? weight_w_ready : ifmap_w_ready;
  assign head_last  = (send_idx == phase_len - LEN_WIDTH'(1));
  assign pop        = head_valid && head_ready;
  assign phase_done = pop && head_last;

  // A beat leaving this cycle frees its slot, so the refill read may go out now;
  // this keeps ready-high streaming at one beat per cycle.
  assign credit = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
  assign rd_en  = sending && (read_idx < phase_len) && (credit < 3'd2);

  assign src_rd_en   = rd_en;
  assign src_rd_addr = rd_en ? phase_base + ADDR_SIZE'(read_idx) : '0;

  assign ifmap_w_valid  = head_valid && !send_w_phase;
  assign ifmap_w_data   = ifmap_w_valid ? head_data : '0;
  assign ifmap_w_last   = ifmap_w_valid && head_last;
  assign weight_w_valid = head_valid && send_w_phase;
  assign weight_w_data  = weight_w_valid ? head_data : '0;
  assign weight_w_last  = weight_w_valid && head_last;

  assign recv_hs     = (state == RECV) && r_valid;
  assign recv_at_end = (recv_idx == result_len_q - LEN_WIDTH'(1));
  assign recv_end    = recv_hs && (r_last || recv_at_end);
  assign recv_err    = recv_hs && (r_last != recv_at_end);

  assign dst_wr_en   = recv_hs;
  assign dst_wr_addr = recv_hs ? result_base_q + ADDR_SIZE'(recv_idx) : '0;
  assign dst_wr_data = recv_hs ? r_data : '0;

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    r_ready   = 1'b0;
    unique case (state)
      IDLE: begin
        if (start)
          state_nxt = first_phase(ifmap_len != '0, weight_len != '0, result_len != '0);
      end
      SEND_I: begin
        busy = 1'b1;
        if (phase_done)
          state_nxt = first_phase(1'b0, weight_len_q != '0, result_len_q != '0);
      end
      SEND_W: begin
        busy = 1'b1;
        if (phase_done)
          state_nxt = first_phase(1'b0, 1'b0, result_len_q != '0);
      end
      RECV: begin
        busy    = 1'b1;
        r_ready = 1'b1;
        if (recv_end) state_nxt = FIN;
      end
      FIN: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Control: state, FIFO bookkeeping, counters, sticky error
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      inflight <= 1'b0;
      occ      <= 2'd0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      read_idx <= '0;
      send_idx <= '0;
      recv_idx <= '0;
      err_last <= 1'b0;
    end else begin
      state    <= state_nxt;
      inflight <= rd_en;
      if (!sending || phase_done) begin
        occ      <= 2'd0;
        wr_ptr   <= 1'b0;
        rd_ptr   <= 1'b0;
        read_idx <= '0;
        send_idx <= '0;
      end else begin
        occ <= 2'(credit);
        if (inflight) wr_ptr <= ~wr_ptr;
        if (pop) begin
          rd_ptr   <= ~rd_ptr;
          send_idx <= send_idx + LEN_WIDTH'(1);
        end
        if (rd_en) read_idx <= read_idx + LEN_WIDTH'(1);
      end
      if (state != RECV)
        recv_idx <= '0;
      else if (recv_hs)
        recv_idx <= recv_idx + LEN_WIDTH'(1);
      if (start_acc)
        err_last <= 1'b0;
      else if (recv_err)
        err_last <= 1'b1;
    end
  end

  // Data: transfer descriptors and FIFO storage
  always_ff @(posedge clk) begin
    if (start_acc) begin
      ifmap_base_q  <= ifmap_base;
      weight_base_q <= weight_base;
      result_base_q <= result_base;
      ifmap_len_q   <= ifmap_len;
      weight_len_q  <= weight_len;
      result_len_q  <= result_len;
    end
    if (sending && inflight)
      fifo_mem[wr_ptr] <= src_rd_data;
  end

endmodule
